// File: rtl/condition_flag_unit_pkg.sv
// Shared condition-code constants and NZCV flag bit positions.
// The ALU and the main decoder import these too.
package condition_flag_unit_pkg;

  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned COND_W    = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_AL = 4'hE;
  localparam logic [COND_W-1:0] COND_NV = 4'hF;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/condition_flag_unit_cond_check.sv
// Combinational condition evaluator: (cond, registered NZCV) -> pass/fail.
module condition_flag_unit_cond_check
  import condition_flag_unit_pkg::*;
(
  input  logic [COND_W-1:0]    cond,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic                 cond_ex
);

  nzcv_t f;
  logic  ge;

  assign f  = nzcv_t'(flags);
  assign ge = (f.n == f.v);

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = f.z;
      COND_NE: cond_ex = ~f.z;
      COND_CS: cond_ex = f.c;
      COND_CC: cond_ex = ~f.c;
      COND_MI: cond_ex = f.n;
      COND_PL: cond_ex = ~f.n;
      COND_VS: cond_ex = f.v;
      COND_VC: cond_ex = ~f.v;
      COND_HI: cond_ex = f.c & ~f.z;
      COND_LS: cond_ex = ~f.c | f.z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~f.z & ge;
      COND_LE: cond_ex = f.z | ~ge;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/condition_flag_unit.sv
// Architectural NZCV register with one-entry save slot; predicates the
// decoder's PC/register/memory write strobes on the registered flags.
module condition_flag_unit
  import condition_flag_unit_pkg::*;
#(
  parameter int unsigned DATA_FLAGS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COND_W-1:0]     cond,
  input  logic [DATA_FLAGS-1:0] alu_flags,
  input  logic [1:0]            flag_w,
  input  logic                  pcs,
  input  logic                  reg_w,
  input  logic                  mem_w,
  input  logic                  save_flags,
  input  logic                  restore_flags,
  output logic                  cond_ex,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic [DATA_FLAGS-1:0] flags,
  output logic [DATA_FLAGS-1:0] saved_flags
);

  logic [DATA_FLAGS-1:0] flags_next;

  // Predication uses only registered flags, so alu_flags never loops into cond_ex.
  condition_flag_unit_cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign pc_src    = pcs   & cond_ex;
  assign reg_write = reg_w & cond_ex;
  assign mem_write = mem_w & cond_ex;

  // Restore beats any ALU update; N,Z and C,V halves update independently.
  always_comb begin
    flags_next = flags;
    if (restore_flags) begin
      flags_next = saved_flags;
    end else if (cond_ex) begin
      if (flag_w[1]) begin
        flags_next[FLAG_N] = alu_flags[FLAG_N];
        flags_next[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (flag_w[0]) begin
        flags_next[FLAG_C] = alu_flags[FLAG_C];
        flags_next[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  // Saving captures the pre-edge flags, so save+restore swaps the registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags       <= '0;
      saved_flags <= '0;
    end else begin
      flags <= flags_next;
      if (save_flags) begin
        saved_flags <= flags;
      end
    end
  end

endmodule

// File: tb/tb_condition_flag_unit.sv
// Self-checking bench for condition_flag_unit: directed table, full cond
// sweep, corner sequences and randomized traffic against a reference model.
module tb_condition_flag_unit;

  logic       clk;
  logic       reset;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs, reg_w, mem_w;
  logic       save_flags, restore_flags;
  logic       cond_ex, pc_src, reg_write, mem_write;
  logic [3:0] flags, saved_flags;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [3:0] mf = 4'h0;
  logic [3:0] ms = 4'h0;

  condition_flag_unit #(.DATA_FLAGS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cond          (cond),
    .alu_flags     (alu_flags),
    .flag_w        (flag_w),
    .pcs           (pcs),
    .reg_w         (reg_w),
    .mem_w         (mem_w),
    .save_flags    (save_flags),
    .restore_flags (restore_flags),
    .cond_ex       (cond_ex),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .flags         (flags),
    .saved_flags   (saved_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] fw;
    logic [3:0] alu;
    logic       save;
    logic       rest;
    logic [2:0] req;
    logic       ce;
    logic [3:0] nf;
    logic [3:0] ns;
  } vec_t;

  vec_t tbl[16];

  // Architectural condition meaning written in terms of N,Z,C,V.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                       input logic s, input logic r, input logic [2:0] req);
    cond = c; flag_w = fw; alu_flags = alu; save_flags = s; restore_flags = r;
    {pcs, reg_w, mem_w} = req;
  endtask

  // Advance the model by one edge from the current inputs, then wait past the edge.
  task automatic clock_model();
    logic [3:0] nf;
    nf = mf;
    if (restore_flags) nf = ms;
    else if (ref_cond(cond, mf)) begin
      if (flag_w[1]) nf[3:2] = alu_flags[3:2];
      if (flag_w[0]) nf[1:0] = alu_flags[1:0];
    end
    if (save_flags) ms = mf;
    mf = nf;
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic ce);
    check({tag, ".pc_src"},    32'(pc_src),    32'(pcs & ce));
    check({tag, ".reg_write"}, 32'(reg_write), 32'(reg_w & ce));
    check({tag, ".mem_write"}, 32'(mem_write), 32'(mem_w & ce));
  endtask

  // Force the flag register to f through an unconditional full update.
  task automatic load_flags(input logic [3:0] f);
    @(negedge clk);
    drive(4'hE, 2'b11, f, 1'b0, 1'b0, 3'b000);
    clock_model();
  endtask

  initial begin
    reset = 1'b1;
    drive(4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 3'b000);
    #1;
    check("reset.flags", 32'(flags), 32'h0);
    check("reset.saved", 32'(saved_flags), 32'h0);
    check("reset.cond_eq", 32'(cond_ex), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //            cond   fw     alu   s     r     req     ce    nf     ns
    tbl[0]  = '{4'h0, 2'b11, 4'h4, 1'b0, 1'b0, 3'b111, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{4'hE, 2'b11, 4'h4, 1'b0, 1'b0, 3'b101, 1'b1, 4'h4, 4'h0};
    tbl[2]  = '{4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 3'b111, 1'b1, 4'h4, 4'h0};
    tbl[3]  = '{4'hE, 2'b11, 4'h2, 1'b0, 1'b0, 3'b010, 1'b1, 4'h2, 4'h0};
    tbl[4]  = '{4'hE, 2'b01, 4'hD, 1'b0, 1'b0, 3'b000, 1'b1, 4'h1, 4'h0};
    tbl[5]  = '{4'hE, 2'b11, 4'h9, 1'b0, 1'b0, 3'b000, 1'b1, 4'h9, 4'h0};
    tbl[6]  = '{4'hE, 2'b00, 4'h0, 1'b1, 1'b0, 3'b000, 1'b1, 4'h9, 4'h9};
    tbl[7]  = '{4'hE, 2'b11, 4'h6, 1'b0, 1'b0, 3'b000, 1'b1, 4'h6, 4'h9};
    tbl[8]  = '{4'hE, 2'b11, 4'hF, 1'b0, 1'b1, 3'b000, 1'b1, 4'h9, 4'h9};
    tbl[9]  = '{4'hE, 2'b11, 4'h3, 1'b0, 1'b0, 3'b000, 1'b1, 4'h3, 4'h9};
    tbl[10] = '{4'hE, 2'b00, 4'h0, 1'b1, 1'b0, 3'b000, 1'b1, 4'h3, 4'h3};
    tbl[11] = '{4'hE, 2'b11, 4'hC, 1'b0, 1'b0, 3'b000, 1'b1, 4'hC, 4'h3};
    tbl[12] = '{4'hE, 2'b00, 4'h0, 1'b1, 1'b1, 3'b000, 1'b1, 4'h3, 4'hC};
    tbl[13] = '{4'h4, 2'b11, 4'hF, 1'b0, 1'b0, 3'b111, 1'b0, 4'h3, 4'hC};
    tbl[14] = '{4'h0, 2'b00, 4'h0, 1'b0, 1'b1, 3'b111, 1'b0, 4'hC, 4'hC};
    tbl[15] = '{4'hC, 2'b00, 4'h0, 1'b0, 1'b0, 3'b111, 1'b0, 4'hC, 4'hC};

    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("tbl[%0d]", i);
      @(negedge clk);
      drive(tbl[i].cond, tbl[i].fw, tbl[i].alu, tbl[i].save, tbl[i].rest, tbl[i].req);
      #1;
      check({tag, ".cond_ex"}, 32'(cond_ex), 32'(tbl[i].ce));
      check_strobes(tag, tbl[i].ce);
      clock_model();
      check({tag, ".flags"}, 32'(flags), 32'(tbl[i].nf));
      check({tag, ".saved"}, 32'(saved_flags), 32'(tbl[i].ns));
    end

    // Asynchronous reset mid-cycle clears both registers before any edge.
    load_flags(4'hF);
    @(negedge clk);
    drive(4'hC, 2'b00, 4'h0, 1'b1, 1'b0, 3'b111);
    clock_model();
    check("pre_rst.flags", 32'(flags), 32'hF);
    check("pre_rst.saved", 32'(saved_flags), 32'hF);
    #2;
    reset = 1'b1;
    mf = 4'h0; ms = 4'h0;
    #1;
    check("async_rst.flags", 32'(flags), 32'h0);
    check("async_rst.saved", 32'(saved_flags), 32'h0);
    check("async_rst.gt", 32'(cond_ex), 32'h1);
    check_strobes("async_rst", 1'b1);
    @(negedge clk);
    reset = 1'b0;
    drive(4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 3'b000);

    // Full cond sweep over every flag value, with random request strobes.
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      check("sweep.flags", 32'(flags), 32'(f));
      for (int c = 0; c < 16; c++) begin
        string tag;
        tag = $sformatf("sweep f=%0h c=%0h", f, c);
        drive(4'(c), 2'b00, 4'h0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
        #1;
        check({tag, " cond_ex"}, 32'(cond_ex), 32'(ref_cond(4'(c), mf)));
        check_strobes(tag, ref_cond(4'(c), mf));
      end
    end

    // Randomized traffic; alu_flags also toggles mid-cycle to show it cannot reach cond_ex.
    for (int i = 0; i < 400; i++) begin
      logic exp_ce;
      @(negedge clk);
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)));
      #1;
      exp_ce = ref_cond(cond, mf);
      check("rand.cond_ex", 32'(cond_ex), 32'(exp_ce));
      alu_flags = ~alu_flags;
      #1;
      check("rand.cond_ex_alu_indep", 32'(cond_ex), 32'(exp_ce));
      check_strobes("rand", exp_ce);
      clock_model();
      check("rand.flags", 32'(flags), 32'(mf));
      check("rand.saved", 32'(saved_flags), 32'(ms));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
